// File: rtl/gray_conv_arbiter_pkg.sv
// gray_conv_arbiter_pkg
//   Shared definitions for the gray_conv_arbiter block:
//   - state_t: sequencer states (IDLE -> CONV -> RESP)
//   - default N_REQ / WIDTH / CNT_W values used by the top module
package gray_conv_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/gray_conv_arbiter_xlate.sv
// gray_xlate
//   Combinational binary<->Gray converter shared by all requesters.
//   Optional feature macro: GRAY_CONV_ARBITER_DECODE_EN
//     defined   : mode = 1 selects Gray-to-binary, mode = 0 binary-to-Gray
//     undefined : always binary-to-Gray, decode path not built, mode unused
// Ports:
//   data_in  [WIDTH-1:0] : word to convert
//   mode                 : 0 = encode, 1 = decode (macro builds only)
//   data_out [WIDTH-1:0] : converted word
module gray_xlate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] enc;

  assign enc = data_in ^ (data_in >> 1);

`ifdef GRAY_CONV_ARBITER_DECODE_EN
  logic [WIDTH-1:0] dec;

  // Each binary bit is the running XOR of all Gray bits from the MSB down.
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = data_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ data_in[i];
    end
  end

  assign data_out = mode ? dec : enc;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign data_out    = enc;
`endif

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Round-robin arbiter that shares one gray_xlate converter among N_REQ
//   requesters. A winner is accepted in IDLE, its word is converted in CONV,
//   and the registered result is held in RESP until the consumer accepts it.
//   Optional feature macro: GRAY_CONV_ARBITER_DECODE_EN (per-request decode
//   via req_mode; without it req_mode is ignored and every request encodes).
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   req_valid  [N_REQ-1:0]    : per-requester valid
//   req_ready  [N_REQ-1:0]    : per-requester accept, one-hot or zero
//   req_data   [N_REQ*WIDTH] : requester i at [i*WIDTH +: WIDTH]
//   req_mode   [N_REQ-1:0]    : 0 = encode, 1 = decode
//   resp_valid/resp_ready     : response handshake
//   resp_data  [WIDTH-1:0]    : converted word
//   resp_id    [ID_W-1:0]     : index of the requester served
//   conv_count [CNT_W-1:0]    : completed response handshakes (wrapping)
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter  int N_REQ = DEFAULT_N_REQ,
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int CNT_W = DEFAULT_CNT_W,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_mode,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic [CNT_W-1:0]       conv_count
);

  state_t state_reg, state_next;

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  logic [ID_W-1:0]  id_reg;
  logic [WIDTH-1:0] data_reg;
  logic             xlate_mode;
  logic [WIDTH-1:0] xlate_out;
  logic             resp_valid_reg;
  logic [WIDTH-1:0] resp_data_reg;
  logic [ID_W-1:0]  resp_id_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] req_word [N_REQ];

  // Unpack the flat data bus and drive the one-hot accept per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin search: first valid index starting at ptr, wrapping.
  always_comb begin
    int               cand;
    logic [ID_W-1:0]  cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(ptr_reg) + k) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Gating with rst_n keeps req_ready low during the reset cycle itself.
  assign accept   = rst_n && (state_reg == IDLE) && grant_found;
  assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (grant_found) state_next = CONV;
      CONV:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef GRAY_CONV_ARBITER_DECODE_EN
  logic mode_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg <= 1'b0;
    end else if (accept) begin
      mode_reg <= req_mode[grant_idx];
    end
  end

  assign xlate_mode = mode_reg;
`else
  logic unused_req_mode;

  assign unused_req_mode = ^req_mode;
  assign xlate_mode      = 1'b0;
`endif

  gray_xlate #(
    .WIDTH (WIDTH)
  ) u_xlate (
    .data_in  (data_reg),
    .mode     (xlate_mode),
    .data_out (xlate_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg        <= '0;
      id_reg         <= '0;
      data_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_id_reg    <= '0;
      count_reg      <= '0;
    end else begin
      if (accept) begin
        data_reg <= req_word[grant_idx];
        id_reg   <= grant_idx;
        ptr_reg  <= ptr_next;
      end
      if (state_reg == CONV) begin
        resp_data_reg  <= xlate_out;
        resp_id_reg    <= id_reg;
        resp_valid_reg <= 1'b1;
      end
      if ((state_reg == RESP) && resp_valid_reg && resp_ready) begin
        resp_valid_reg <= 1'b0;
        count_reg      <= count_reg + 1'b1;
      end
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign conv_count = count_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Testbench for gray_conv_arbiter: transaction-level model plus directed
// scenarios with literal expected results.
module tb_gray_conv_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = 16;
  localparam int IW = 2;
`ifdef GRAY_CONV_ARBITER_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_mode = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [W-1:0]    resp_data;
  logic [IW-1:0]   resp_id;
  logic [CW-1:0]   conv_count;

  always #5 clk = ~clk;

  gray_conv_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_mode   (req_mode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .conv_count (conv_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- requester queues and driver ----------------
  logic [W:0] req_q [N][$];   // {mode, data}
  logic [N-1:0] granted_mask = '0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted_mask[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
      if (req_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = req_q[i][0][W-1:0];
        req_mode[i]        = req_q[i][0][W];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    granted_mask = '0;
  end

  // ---------------- behavioural model ----------------
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] conv(input logic [W-1:0] x, input logic m);
    logic [W-1:0] r;
    if (m && DEC_EN) begin
      for (int i = 0; i < W; i++) r[i] = ^(x >> i);
    end else begin
      r = x ^ (x >> 1);
    end
    return r;
  endfunction

  bit           live = 1'b0;
  bit           m_pending;
  int           m_age, m_ptr, m_cnt, m_id, m_out_id, m_w;
  logic [W-1:0] m_res, m_out_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 1'b0; m_age = 0; m_ptr = 0; m_cnt = 0;
      m_id = 0; m_out_id = 0; m_res = '0; m_out_data = '0;
    end else if (m_pending) begin
      if (m_age >= 2 && resp_ready) begin
        m_pending = 1'b0;
        m_cnt     = (m_cnt + 1) % (1 << CW);
      end else if (m_age < 2) begin
        m_age++;
        if (m_age == 2) begin
          m_out_data = m_res;
          m_out_id   = m_id;
        end
      end
    end else begin
      m_w = pick(req_valid, m_ptr);
      if (m_w >= 0) begin
        m_pending = 1'b1;
        m_age     = 1;
        m_id      = m_w;
        m_res     = conv(req_data[m_w*W +: W], req_mode[m_w]);
        m_ptr     = (m_w + 1) % N;
      end
    end
    live = 1'b1;
  end

  typedef struct { int id; logic [W-1:0] data; } txn_t;
  txn_t log_q[$];
  logic [N-1:0] exp_rr;
  int           exp_w;

  always @(negedge clk) begin
    if (live) begin
      exp_rr = '0;
      if (rst_n && !m_pending) begin
        exp_w = pick(req_valid, m_ptr);
        if (exp_w >= 0) exp_rr[exp_w] = 1'b1;
      end
      chk("req_ready",  32'(req_ready),  32'(exp_rr));
      chk("resp_valid", 32'(resp_valid), 32'(m_pending && m_age >= 2));
      chk("resp_data",  32'(resp_data),  32'(m_out_data));
      chk("resp_id",    32'(resp_id),    32'(m_out_id));
      chk("conv_count", 32'(conv_count), 32'(m_cnt));
      granted_mask = req_ready;
      if (rst_n && resp_valid && resp_ready) begin
        log_q.push_back('{id: int'(resp_id), data: resp_data});
        $display("txn %0d: id=%0d data=%b count_before=%0d", log_q.size(), resp_id, resp_data, conv_count);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic push(input int i, input logic m, input logic [W-1:0] d);
    req_q[i].push_back({m, d});
  endtask

  task automatic wait_log(input int target, input int budget);
    int c = 0;
    while (log_q.size() < target && c < budget) begin
      step();
      c++;
    end
    chk("handshakes_seen", 32'(log_q.size()), 32'(target));
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (resp_valid !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic chk_log(input string name, input int idx, input int id, input logic [W-1:0] d);
    if (idx < log_q.size()) begin
      chk({name, "_id"},   32'(log_q[idx].id),   32'(id));
      chk({name, "_data"}, 32'(log_q[idx].data), 32'(d));
    end else begin
      chk({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    resp_ready = 1'b1;
    // Single request, held valid while reset is low.
    push(0, 1'b0, 4'b0101);
    step(2);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  32'(resp_data),  32'd0);
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_conv_count", 32'(conv_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_accept", 32'(req_ready), 32'b0001);
    step();
    chk("t1_conv_valid", 32'(resp_valid), 32'd0);
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_resp_data",  32'(resp_data),  32'b0111);
    chk("t1_resp_id",    32'(resp_id),    32'd0);
    step();
    chk("t1_count", 32'(conv_count), 32'd1);
    chk_log("t1", 0, 0, 4'b0111);

    // All four requesters at once after reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    base = log_q.size();
    push(0, 1'b0, 4'b0011);
    push(1, 1'b0, 4'b0100);
    push(2, 1'b0, 4'b1000);
    push(3, 1'b0, 4'b1001);
    wait_log(base + 4, 40);
    chk_log("t2_0", base + 0, 0, 4'b0010);
    chk_log("t2_1", base + 1, 1, 4'b0110);
    chk_log("t2_2", base + 2, 2, 4'b1100);
    chk_log("t2_3", base + 3, 3, 4'b1101);
    chk("t2_count", 32'(conv_count), 32'd4);

    // Backpressure in RESP for 5 cycles.
    resp_ready = 1'b0;
    base = log_q.size();
    push(1, 1'b0, 4'b0110);
    wait_valid(20);
    push(3, 1'b0, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data",  32'(resp_data),  32'b0101);
      chk("bp_id",    32'(resp_id),    32'd1);
      chk("bp_ready", 32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    wait_log(base + 2, 20);
    chk_log("bp_0", base + 0, 1, 4'b0101);
    chk_log("bp_1", base + 1, 3, 4'b1010);

    // Fairness: req0 and req2 both continuously valid.
    base = log_q.size();
    push(0, 1'b0, 4'b0001);
    push(0, 1'b0, 4'b0010);
    push(2, 1'b0, 4'b0011);
    push(2, 1'b0, 4'b1111);
    wait_log(base + 4, 40);
    chk_log("fair_0", base + 0, 0, 4'b0001);
    chk_log("fair_1", base + 1, 2, 4'b0010);
    chk_log("fair_2", base + 2, 0, 4'b0011);
    chk_log("fair_3", base + 3, 2, 4'b1000);

    // Decode mode request.
    base = log_q.size();
    push(1, 1'b1, 4'b0111);
    wait_log(base + 1, 20);
    chk_log("dec", base, 1, DEC_EN ? 4'b0101 : 4'b0100);

    // Reset while a result is pending in RESP.
    resp_ready = 1'b0;
    push(2, 1'b0, 4'b1010);
    wait_valid(20);
    chk("pre_rst_count", 32'(conv_count), 32'd11);
    push(1, 1'b0, 4'b0001);
    push(3, 1'b0, 4'b0010);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_count", 32'(conv_count), 32'd0);
    chk("mid_rst_data",  32'(resp_data),  32'd0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    base = log_q.size();
    wait_log(base + 2, 20);
    chk_log("post_rst_0", base + 0, 1, 4'b0001);
    chk_log("post_rst_1", base + 1, 3, 4'b0011);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray converter between `N_REQ` requesters. Each requester hands over a `WIDTH`-bit word with a valid/ready handshake. The block latches the winning word, converts it through the shared datapath, and holds the registered result plus requester ID on a single response port until it is accepted. A wrapping counter reports how many conversions have completed.

## Interface
- `N_REQ`, default 4: number of requesters (≥2).
- `WIDTH`, default 4: data word width (≥2).
- `CNT_W`, default 16: width of the completed-conversion counter.
- `ID_W`, derived as `$clog2(N_REQ)`: requester ID width.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `req_valid`  input  N_REQ: per-requester valid.
- `req_ready`  output  N_REQ: per-requester accept (one-hot or zero).
- `req_data`  input  N_REQ*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH].
- `req_mode`  input  N_REQ: per-requester mode (0 = encode, 1 = decode); honoured only with the macro.
- `resp_valid`  output  1: result available.
- `resp_ready`  input  1: consumer accepts the result.
- `resp_data`  output  WIDTH: converted word.
- `resp_id`  output  ID_W: index of the requester that produced the result.
- `conv_count`  output  CNT_W: number of completed response handshakes.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, grant the first valid index searching from `ptr` upward, with wrap. Assert `req_ready[winner]` combinationally in the same cycle. Latch data, mode and ID. Set `ptr` to (winner+1) mod N_REQ. Go to CONV. If no request is valid, stay in IDLE.
  - CONV: register the converter output into `resp_data` and the ID into `resp_id`. Set `resp_valid`. Go to RESP.
  - RESP: hold all `resp_*` outputs stable. On `resp_valid && resp_ready`, clear `resp_valid`, increment `conv_count`, and go to IDLE.
- `req_ready` is all-zero outside IDLE and while `rst_n` is low.
- Encode: g = b ^ (b >> 1).
- Decode: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- `conv_count` wraps from 2^CNT_W−1 to 0 without any flag.
- Requesters must hold `req_valid` and their data until their `req_ready` is high. The block does not check this.
- A requester that drops `req_valid` before being granted is simply not granted.

## Timing
- Reset (`rst_n` low at a clock edge) puts the block in this state:
  - FSM in IDLE, `ptr` = 0
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0
  - `conv_count` = 0, `req_ready` = 0
- Latency: accept at edge t, then `resp_valid` is high after edge t+2.
- Minimum period is 3 cycles per conversion: accept in IDLE, then CONV, then RESP with `resp_ready` already high.
- Response backpressure stalls the block in RESP indefinitely. No new accepts occur during the stall.
- Reset asserted mid-operation, in CONV or RESP, discards the pending result. No handshake completes in that cycle.
- Multiple valid requests arriving in the same cycle are resolved purely by `ptr`.

## Configuration
- `GRAY_CONV_ARBITER_DECODE_EN`:
  - When defined: the latched `req_mode` bit selects Gray-to-binary (1) or binary-to-Gray (0) conversion.
  - When undefined: `req_mode` is ignored, every conversion is binary-to-Gray, and the decode logic is not instantiated. The port list is unchanged in both cases.

## Structure
- Package `gray_conv_arbiter_pkg` holds:
  - the state enum typedef: IDLE = 2'b00, CONV = 2'b01, RESP = 2'b10
  - the default WIDTH, N_REQ and CNT_W constants
- Sub-module `gray_xlate`: combinational, WIDTH-parameterised converter with `mode` input. Its decode path sits under the same macro.
- The round-robin priority search stays in the top module.

## Test plan
- Single request: req0 data 4'b0101, mode 0 -> `resp_data` 4'b0111, `resp_id` 0, `resp_valid` high 2 cycles after accept, `conv_count` 1 after handshake.
- All four requesters valid after reset with 0011, 0100, 1000, 1001 and `resp_ready` = 1 -> served in order 0, 1, 2, 3 with results 0010, 0110, 1100, 1101; `conv_count` = 4.
- Backpressure: `resp_ready` = 0 for 5 cycles while in RESP -> `resp_data`/`resp_id` stable, `resp_valid` held, `req_ready` all zero.
- Fairness: req0 and req2 continuously valid -> grant order 0, 2, 0, 2.
- Decode mode: req1 mode 1, data 0111 -> 0101 with the macro; 0100 without the macro.
- Reset in RESP: `rst_n` low for one cycle while `resp_valid` is high -> next cycle `resp_valid` 0, `conv_count` 0, next grant goes to the lowest valid index starting from 0.
